// File: rtl/pulse_amp_memory_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pulse_amp_memory_writer_pkg
// Purpose : Shared types and default geometry for the amp memory writer.
//           Provides the FSM state enumeration and default widths.
// Ports   : (package, no ports)
// Rev     : 1.0  initial release
// ============================================================================
package pulse_amp_memory_writer_pkg;

  // Default geometry. The memory address is {direction, sample index}.
  localparam int PAW_DIRECTION_WIDTH       = 2;
  localparam int PAW_AMP_MEMORY_ADDR_WIDTH = 9;
  localparam int PAW_AMP_DATA_WIDTH        = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } paw_state_t;

endpackage : pulse_amp_memory_writer_pkg
`default_nettype wire

// File: rtl/pulse_amp_memory_writer_counter.sv
`default_nettype none
// ============================================================================
// Module  : pulse_amp_memory_writer_counter
// Purpose : Free-wrapping up-counter used as the in-bank sample index.
// Ports   : clk   - clock
//           rst   - synchronous active-high clear (also used to restart a load)
//           en    - increment enable
//           count - current count value
// Rev     : 1.0  initial release
// ============================================================================
module pulse_amp_memory_writer_counter #(
  parameter int COUNT_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : pulse_amp_memory_writer_counter
`default_nettype wire

// File: rtl/pulse_amp_memory_writer.sv
`default_nettype none
// ============================================================================
// Module  : pulse_amp_memory_writer
// Purpose : Loads amplitude samples from a valid/ready stream into one
//           direction bank of the amp memory at address {direction, index}.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           start, abort        - begin / cancel a load
//           direction_in        - target bank (latched on accepted start)
//           length_in           - sample count 0..DEPTH (saturated above DEPTH)
//           sample_valid/_data  - upstream sample stream
//           sample_ready        - upstream handshake ready
//           amp_memory_wr_*     - registered memory write port
//           busy                - high whenever not IDLE
//           done                - one-cycle completion pulse
// Rev     : 1.0  initial release
// ============================================================================
module pulse_amp_memory_writer
  import pulse_amp_memory_writer_pkg::*;
#(
  parameter int DIRECTION_WIDTH       = PAW_DIRECTION_WIDTH,
  parameter int AMP_MEMORY_ADDR_WIDTH = PAW_AMP_MEMORY_ADDR_WIDTH,
  parameter int AMP_DATA_WIDTH        = PAW_AMP_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic [DIRECTION_WIDTH-1:0]        direction_in,
  input  logic [AMP_MEMORY_ADDR_WIDTH-DIRECTION_WIDTH:0] length_in,
  input  logic                              sample_valid,
  input  logic [AMP_DATA_WIDTH-1:0]         sample_data,
  output logic                              sample_ready,
  output logic                              amp_memory_wr_en,
  output logic [AMP_MEMORY_ADDR_WIDTH-1:0]  amp_memory_wr_addr,
  output logic [AMP_DATA_WIDTH-1:0]         amp_memory_wr_data,
  output logic                              busy,
  output logic                              done
);

  localparam int COUNTER_WIDTH = AMP_MEMORY_ADDR_WIDTH - DIRECTION_WIDTH;
  // DEPTH expressed in the length width: a single 1 above the counter bits.
  localparam logic [COUNTER_WIDTH:0] DEPTH_LEN = {1'b1, {COUNTER_WIDTH{1'b0}}};
  localparam logic [COUNTER_WIDTH:0] LEN_ONE   = {{COUNTER_WIDTH{1'b0}}, 1'b1};

  paw_state_t                       state_q,   state_d;
  logic [DIRECTION_WIDTH-1:0]       dir_q,     dir_d;
  logic [COUNTER_WIDTH:0]           len_q,     len_d;
  logic                             wr_en_q,   wr_en_d;
  logic [AMP_MEMORY_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [AMP_DATA_WIDTH-1:0]        wr_data_q, wr_data_d;

  logic                     w_start_accept;
  logic                     w_accept;
  logic                     w_last;
  logic [COUNTER_WIDTH-1:0] w_count;
  logic [COUNTER_WIDTH:0]   w_count_next;
  logic [COUNTER_WIDTH:0]   w_len_sat;

  assign sample_ready   = (state_q == ST_WRITE) && !abort;
  assign w_accept       = sample_valid && sample_ready;
  assign w_start_accept = (state_q == ST_IDLE) && start;

  // One bit wider than the counter so a full-bank load (len == DEPTH) can
  // match on the final sample even though the counter itself wraps to 0.
  assign w_count_next = {1'b0, w_count} + LEN_ONE;
  assign w_last       = (w_count_next == len_q);
  assign w_len_sat    = (length_in > DEPTH_LEN) ? DEPTH_LEN : length_in;

  pulse_amp_memory_writer_counter #(
    .COUNT_WIDTH (COUNTER_WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst | w_start_accept),
    .en    (w_accept),
    .count (w_count)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d   = direction_in;
          len_d   = w_len_sat;
          state_d = (w_len_sat == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (w_accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {dir_q, w_count};
          wr_data_d = sample_data;
          if (w_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= '0;
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign amp_memory_wr_en   = wr_en_q;
  assign amp_memory_wr_addr = wr_addr_q;
  assign amp_memory_wr_data = wr_data_q;
  assign busy               = (state_q != ST_IDLE);
  assign done               = (state_q == ST_DONE);

endmodule : pulse_amp_memory_writer
`default_nettype wire

// File: tb/tb_pulse_amp_memory_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pulse_amp_memory_writer
// Purpose : Directed self-checking bench for pulse_amp_memory_writer.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pulse_amp_memory_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  direction_in = '0;
  logic [7:0]  length_in = '0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_ready;
  logic        amp_memory_wr_en;
  logic [8:0]  amp_memory_wr_addr;
  logic [15:0] amp_memory_wr_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state
  logic        mon_en = 1'b0;
  logic [24:0] exp_q[$];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          idle_wr_cnt = 0;

  always #5 clk = ~clk;

  pulse_amp_memory_writer #(
    .DIRECTION_WIDTH       (2),
    .AMP_MEMORY_ADDR_WIDTH (9),
    .AMP_DATA_WIDTH        (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .abort              (abort),
    .direction_in       (direction_in),
    .length_in          (length_in),
    .sample_valid       (sample_valid),
    .sample_data        (sample_data),
    .sample_ready       (sample_ready),
    .amp_memory_wr_en   (amp_memory_wr_en),
    .amp_memory_wr_addr (amp_memory_wr_addr),
    .amp_memory_wr_data (amp_memory_wr_data),
    .busy               (busy),
    .done               (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every write must match the next expected {addr,data}.
  always @(negedge clk) begin
    if (mon_en) begin
      if (amp_memory_wr_en === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {7'd0, amp_memory_wr_addr, amp_memory_wr_data}, 32'hFFFF_FFFF);
        end else begin
          logic [24:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {23'd0, amp_memory_wr_addr}, {23'd0, e[24:16]});
          chk("wr_data", {16'd0, amp_memory_wr_data}, {16'd0, e[15:0]});
        end
      end else if (busy === 1'b1) begin
        idle_wr_cnt++;
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_cnt = 0;
    done_cnt = 0;
    idle_wr_cnt = 0;
  endtask

  task automatic do_start(input logic [1:0] dir, input logic [7:0] len);
    start        = 1'b1;
    direction_in = dir;
    length_in    = len;
    tick();
    start        = 1'b0;
    direction_in = '0;
    length_in    = '0;
  endtask

  // Present one sample, hold until accepted (bounded), then idle `gap` cycles.
  task automatic send(input logic [15:0] d, input int gap);
    int waited;
    sample_valid = 1'b1;
    sample_data  = d;
    waited = 0;
    @(negedge clk);
    while (sample_ready !== 1'b1 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 20) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    sample_valid = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (3) tick();
    chk("rst_wr_en",   {31'd0, amp_memory_wr_en}, 32'd0);
    chk("rst_wr_addr", {23'd0, amp_memory_wr_addr}, 32'd0);
    chk("rst_wr_data", {16'd0, amp_memory_wr_data}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_done",    {31'd0, done}, 32'd0);
    chk("rst_ready",   {31'd0, sample_ready}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // ---------------- T1: dir=2, len=4, back-to-back ----------------
    clear_stats();
    for (int i = 0; i < 4; i++) exp_q.push_back({9'h100 + 9'(i), 16'h0011 + 16'(i)});
    do_start(2'b10, 8'd4);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) send(16'h0011 + 16'(i), 0);
    chk("t1_done",      {31'd0, done}, 32'd1);
    chk("t1_last_wren", {31'd0, amp_memory_wr_en}, 32'd1);
    chk("t1_last_addr", {23'd0, amp_memory_wr_addr}, 32'h103);
    tick();
    chk("t1_busy_fall", {31'd0, busy}, 32'd0);
    chk("t1_done_fall", {31'd0, done}, 32'd0);
    tick();
    chk("t1_writes", wr_cnt, 4);
    chk("t1_done_cnt", done_cnt, 1);

    // ---------------- T2: len=0 ----------------
    clear_stats();
    do_start(2'b01, 8'd0);
    chk("t2_done",  {31'd0, done}, 32'd1);
    chk("t2_ready", {31'd0, sample_ready}, 32'd0);
    chk("t2_wr_en", {31'd0, amp_memory_wr_en}, 32'd0);
    tick();
    chk("t2_busy_fall", {31'd0, busy}, 32'd0);
    tick();
    chk("t2_writes", wr_cnt, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // ---------------- T3: len=200 saturates to 128, gapped ----------------
    clear_stats();
    for (int i = 0; i < 128; i++) exp_q.push_back({9'h180 + 9'(i), 16'h1000 + 16'(i)});
    do_start(2'b11, 8'd200);
    for (int i = 0; i < 128; i++) send(16'h1000 + 16'(i), 1);
    repeat (3) tick();
    chk("t3_writes", wr_cnt, 128);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_gap_cycles", idle_wr_cnt, 128);
    chk("t3_idle", {31'd0, busy}, 32'd0);
    chk("t3_queue_empty", exp_q.size(), 0);

    // ---------------- T4: start mid-load ignored ----------------
    clear_stats();
    for (int i = 0; i < 3; i++) exp_q.push_back({9'h100 + 9'(i), 16'h0A00 + 16'(i)});
    do_start(2'b10, 8'd3);
    send(16'h0A00, 0);
    do_start(2'b00, 8'd5);
    send(16'h0A01, 0);
    send(16'h0A02, 0);
    chk("t4_done", {31'd0, done}, 32'd1);
    repeat (3) tick();
    chk("t4_writes", wr_cnt, 3);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // ---------------- T5: abort after 2 accepts ----------------
    clear_stats();
    exp_q.push_back({9'h080, 16'h00A0});
    exp_q.push_back({9'h081, 16'h00A1});
    do_start(2'b01, 8'd6);
    send(16'h00A0, 0);
    send(16'h00A1, 0);
    abort        = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 16'h00A2;
    #2;
    chk("t5_ready_abort", {31'd0, sample_ready}, 32'd0);
    tick();
    abort        = 1'b0;
    sample_valid = 1'b0;
    chk("t5_idle", {31'd0, busy}, 32'd0);
    chk("t5_no_done", {31'd0, done}, 32'd0);
    repeat (2) tick();
    chk("t5_writes", wr_cnt, 2);
    chk("t5_done_cnt", done_cnt, 0);
    exp_q.push_back({9'h080, 16'h00B0});
    do_start(2'b01, 8'd1);
    send(16'h00B0, 0);
    chk("t5b_done", {31'd0, done}, 32'd1);
    repeat (2) tick();
    chk("t5b_writes", wr_cnt, 3);

    // ---------------- T6: reset mid-load ----------------
    clear_stats();
    for (int i = 0; i < 3; i++) exp_q.push_back({9'h000 + 9'(i), 16'h0C00 + 16'(i)});
    do_start(2'b00, 8'd10);
    for (int i = 0; i < 3; i++) send(16'h0C00 + 16'(i), 0);
    rst          = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 16'h0CFF;
    tick();
    chk("t6_wr_en",   {31'd0, amp_memory_wr_en}, 32'd0);
    chk("t6_wr_addr", {23'd0, amp_memory_wr_addr}, 32'd0);
    chk("t6_wr_data", {16'd0, amp_memory_wr_data}, 32'd0);
    chk("t6_busy",    {31'd0, busy}, 32'd0);
    chk("t6_done",    {31'd0, done}, 32'd0);
    chk("t6_ready",   {31'd0, sample_ready}, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("t6_ready_after", {31'd0, sample_ready}, 32'd0);
    end
    sample_valid = 1'b0;
    tick();
    chk("t6_writes", wr_cnt, 3);
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pulse_amp_memory_writer
`default_nettype wire

// File: doc/pulse_amp_memory_writer.md
Name: pulse_amp_memory_writer

Overview:
Write-side counterpart of the pulse amplitude memory read-address path. It loads amplitude samples into one direction bank of the amp memory.
- A start command latches a direction and a sample count.
- Samples are then taken from an upstream valid/ready stream.
- Each sample is written at address {direction, count}, with count running 0..N-1. This is the same address layout the read-side address generator walks.
- Sits between the host/config loader and the amp memory write port.

Parameters:
DIRECTION_WIDTH, 2, width of direction/bank select (address MSBs)
AMP_MEMORY_ADDR_WIDTH, 9, amp memory address width
AMP_DATA_WIDTH, 16, amplitude sample width
(localparam COUNTER_WIDTH = AMP_MEMORY_ADDR_WIDTH - DIRECTION_WIDTH = 7; bank depth DEPTH = 2^COUNTER_WIDTH = 128)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a load; sampled only in IDLE
abort  in  1  terminate a load without done
direction_in  in  DIRECTION_WIDTH  target bank, latched on accepted start
length_in  in  COUNTER_WIDTH+1  samples to write (0..DEPTH), latched on accepted start
sample_valid  in  1  upstream sample valid
sample_data  in  AMP_DATA_WIDTH  amplitude sample
sample_ready  out  1  upstream handshake ready
amp_memory_wr_en  out  1  memory write enable (registered)
amp_memory_wr_addr  out  AMP_MEMORY_ADDR_WIDTH  write address (registered)
amp_memory_wr_data  out  AMP_DATA_WIDTH  write data (registered)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst).
- Reset values: state=IDLE; wr_en, wr_addr, wr_data, done, busy, sample_ready, count, dir_reg and len_reg all 0.
- States: IDLE, WRITE, DONE.
- IDLE:
  - On start, latch dir_reg and len_reg and clear count.
  - len_reg = min(length_in, DEPTH); values above DEPTH saturate.
  - If the saturated length is 0, go to DONE; otherwise go to WRITE.
- WRITE:
  - sample_ready=1 combinationally (state==WRITE && !abort).
  - Accept = sample_valid && sample_ready.
  - On accept, at the next edge: wr_en<=1, wr_addr<={dir_reg, count}, wr_data<=sample_data, count<=count+1.
  - If count+1 == len_reg, go to DONE.
  - Without an accept, wr_en<=0.
  - Latency: a sample accepted in cycle N appears on the write port in cycle N+1.
  - Back-to-back accepts give one write per cycle.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - The final write (wr_en=1) appears in the same cycle as done.
  - sample_ready=0.
- Count is COUNTER_WIDTH bits. With len=DEPTH the last address is {dir,127}; count wraps to 0 at that point and is unused.
- start outside IDLE, including in the DONE cycle, is ignored. A new start is accepted the cycle after done at the earliest.
- abort in WRITE:
  - sample_ready drops in that cycle, so no accept occurs.
  - Next state is IDLE with no done pulse.
  - A write registered from the previous cycle still completes.
- abort in IDLE or DONE has no effect.
- rst has priority over everything. rst mid-load returns to IDLE the next cycle with wr_en=0 and no done pulse. Memory contents already written are unaffected.
- direction_in and length_in are don't-care outside the accepted-start cycle.
- wr_addr and wr_data hold their last value when wr_en=0.

Decomposition:
- State encodings (IDLE=2'd0, WRITE=2'd1, DONE=2'd2) go in define_pulse_circuit.v as `define constants.
- Write counter: instantiate counter_param with COUNT_WIDTH=COUNTER_WIDTH.
  - Its rst is driven by rst | (start accepted in IDLE).
  - Its en is driven by accept.
- FSM, length compare and output registers stay in this module.

Test Plan:
- Reset then start, dir=2'b10, len=4, four consecutive valid samples 0x0011..0x0014 -> wr_en for 4 cycles at addresses 0x100..0x103 with matching data; done pulses with the 0x103 write; busy falls next cycle.
- len=0, dir=1 -> done pulses the cycle after start; no wr_en; sample_ready never high.
- len=200 (saturated), dir=3, sample_valid gapped every other cycle -> exactly 128 writes at 0x180..0x1FF, no extra write, done once; the gaps produce wr_en=0 cycles.
- start re-asserted mid-load with dir=0, len=5 -> ignored; the original load completes unchanged.
- abort after 2 accepts of len=6, dir=1 -> writes at 0x080 and 0x081 only; no done; IDLE next cycle; a following start with len=1 works.
- rst asserted after 3 writes -> next cycle all outputs 0 and state IDLE; further samples not accepted.
